// File: rtl/bool_func_unit.sv
// Programmable N-input Boolean function unit.
// Holds a 2^N_IN-entry truth table, loaded one minterm per command. It can
// evaluate one input vector, or sweep every input combination in turn and
// count how many minterms are true.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepts EVAL / LOAD / SWEEP / CLEAR commands
// SWEEP | walks idx 0..2^N_IN-1, one result per cycle, commands ignored
module bool_func_unit #(
   parameter int N_IN = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   input  logic [1:0]      cmd_op,
   output logic            cmd_ready,
   input  logic [N_IN-1:0] in_vec,
   input  logic            load_bit,
   output logic            F,
   output logic            f_valid,
   output logic [N_IN-1:0] sweep_idx,
   output logic [N_IN:0]   ones_cnt,
   output logic            done
);

   localparam int DEPTH = 1 << N_IN;

   localparam logic [1:0] OP_EVAL  = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_SWEEP = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SWEEP = 1'b1
   } state_e;

   state_e            state_q,     state_d;
   logic [DEPTH-1:0]  table_q,     table_d;
   logic              f_q,         f_d;
   logic              f_valid_q,   f_valid_d;
   logic              done_q,      done_d;
   logic [N_IN-1:0]   sweep_idx_q, sweep_idx_d;
   logic [N_IN:0]     ones_cnt_q,  ones_cnt_d;
   logic [N_IN:0]     acc_q,       acc_d;
   logic [N_IN-1:0]   idx_q,       idx_d;
   logic [N_IN:0]     acc_next;

   assign cmd_ready = (state_q == S_IDLE);
   assign F         = f_q;
   assign f_valid   = f_valid_q;
   assign done      = done_q;
   assign sweep_idx = sweep_idx_q;
   assign ones_cnt  = ones_cnt_q;

   // Running count including the entry being swept this cycle; one bit wider
   // than idx so a full table reports 2^N_IN.
   assign acc_next = acc_q + {{N_IN{1'b0}}, table_q[idx_q]};

   // Next-state, table update and output computation; pulses default low.
   always_comb begin
      state_d     = state_q;
      table_d     = table_q;
      f_d         = f_q;
      f_valid_d   = 1'b0;
      done_d      = 1'b0;
      sweep_idx_d = sweep_idx_q;
      ones_cnt_d  = ones_cnt_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_EVAL: begin
                     f_d         = table_q[in_vec];
                     f_valid_d   = 1'b1;
                     sweep_idx_d = '0;
                  end
                  OP_LOAD:  table_d[in_vec] = load_bit;
                  OP_SWEEP: begin
                     state_d = S_SWEEP;
                     idx_d   = '0;
                     acc_d   = '0;
                  end
                  OP_CLEAR: table_d = '0;
                  default:  table_d = table_q;
               endcase
            end
         end
         S_SWEEP: begin
            f_d         = table_q[idx_q];
            sweep_idx_d = idx_q;
            f_valid_d   = 1'b1;
            acc_d       = acc_next;
            idx_d       = idx_q + 1'b1;
            // Terminal check on the current idx, before it wraps to 0.
            if (idx_q == {N_IN{1'b1}}) begin
               ones_cnt_d = acc_next;
               done_d     = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous reset; reset also clears the table.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         table_q     <= '0;
         f_q         <= 1'b0;
         f_valid_q   <= 1'b0;
         done_q      <= 1'b0;
         sweep_idx_q <= '0;
         ones_cnt_q  <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         table_q     <= table_d;
         f_q         <= f_d;
         f_valid_q   <= f_valid_d;
         done_q      <= done_d;
         sweep_idx_q <= sweep_idx_d;
         ones_cnt_q  <= ones_cnt_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
      end
   end

endmodule

// File: tb/tb_bool_func_unit.sv
// Self-checking bench for bool_func_unit (N_IN = 5).
module tb_bool_func_unit;

   localparam int N     = 5;
   localparam int DEPTH = 1 << N;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic [1:0]    cmd_op;
   logic          cmd_ready;
   logic [N-1:0]  in_vec;
   logic          load_bit;
   logic          f_out;
   logic          f_valid;
   logic [N-1:0]  sweep_idx;
   logic [N:0]    ones_cnt;
   logic          done;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: truth table as a plain array, plus last F.
   bit model_tbl [DEPTH];
   bit exp_f;
   int exp_ones;

   bool_func_unit #(.N_IN(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_ready (cmd_ready),
      .in_vec    (in_vec),
      .load_bit  (load_bit),
      .F         (f_out),
      .f_valid   (f_valid),
      .sweep_idx (sweep_idx),
      .ones_cnt  (ones_cnt),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       valid;
      bit [1:0] op;
      bit [4:0] vec;
      bit       lbit;
      bit       exp_f;
      bit       exp_fv;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock edge; outputs are stable 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int count_ones();
      int c = 0;
      foreach (model_tbl[i]) c += model_tbl[i];
      return c;
   endfunction

   task automatic issue(input bit [1:0] op, input int vec, input bit lb);
      cmd_valid = 1'b1;
      cmd_op    = op;
      in_vec    = N'(vec);
      load_bit  = lb;
      step();
      cmd_valid = 1'b0;
      case (op)
         2'b00: exp_f = model_tbl[vec];
         2'b01: model_tbl[vec] = lb;
         2'b11: foreach (model_tbl[i]) model_tbl[i] = 1'b0;
         default: ;
      endcase
   endtask

   // Full sweep; optionally presents random EVAL/LOAD junk while busy.
   task automatic run_sweep(input bit junk);
      issue(2'b10, 0, 1'b0);
      check("sweep_busy_ready", cmd_ready, 0);
      for (int k = 0; k < DEPTH; k++) begin
         if (junk) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom_range(0, 1));
            in_vec    = N'($urandom);
            load_bit  = 1'($urandom);
         end
         step();
         check("sweep_fvalid", f_valid, 1);
         check("sweep_F", f_out, model_tbl[k]);
         check("sweep_idx", sweep_idx, k);
         check("sweep_done", done, (k == DEPTH - 1) ? 1 : 0);
         check("sweep_ready", cmd_ready, (k == DEPTH - 1) ? 1 : 0);
      end
      cmd_valid = 1'b0;
      exp_ones  = count_ones();
      exp_f     = model_tbl[DEPTH-1];
      check("sweep_ones_cnt", ones_cnt, exp_ones);
      step();
      check("post_sweep_done", done, 0);
      check("post_sweep_fvalid", f_valid, 0);
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; in_vec = '0; load_bit = 1'b0;
      foreach (model_tbl[i]) model_tbl[i] = 1'b0;
      exp_f = 1'b0; exp_ones = 0;
      step(); step();
      rst = 1'b0;
      check("rst_F", f_out, 0);
      check("rst_fvalid", f_valid, 0);
      check("rst_done", done, 0);
      check("rst_sweep_idx", sweep_idx, 0);
      check("rst_ones_cnt", ones_cnt, 0);
      check("rst_ready", cmd_ready, 1);

      // {valid, op, vec, load_bit, expected F, expected f_valid}
      vecs[0] = '{1, 2'b00, 5'b00000, 0, 0, 1};
      vecs[1] = '{1, 2'b01, 5'b01010, 1, 0, 0};
      vecs[2] = '{1, 2'b01, 5'b11001, 1, 0, 0};
      vecs[3] = '{1, 2'b00, 5'b01010, 0, 1, 1};
      vecs[4] = '{0, 2'b00, 5'b00000, 0, 1, 0};
      vecs[5] = '{1, 2'b00, 5'b11001, 0, 1, 1};
      vecs[6] = '{1, 2'b00, 5'b00000, 0, 0, 1};
      vecs[7] = '{1, 2'b00, 5'b01010, 0, 1, 1};
      vecs[8] = '{1, 2'b00, 5'b11001, 1, 1, 1};
      foreach (vecs[i]) begin
         cmd_valid = vecs[i].valid;
         cmd_op    = vecs[i].op;
         in_vec    = vecs[i].vec;
         load_bit  = vecs[i].lbit;
         step();
         check("vec_F", f_out, vecs[i].exp_f);
         check("vec_fvalid", f_valid, vecs[i].exp_fv);
         check("vec_ready", cmd_ready, 1);
         if (vecs[i].exp_fv) check("vec_sweep_idx", sweep_idx, 0);
      end
      cmd_valid = 1'b0;
      model_tbl[10] = 1'b1;
      model_tbl[25] = 1'b1;

      // Sweep with idx 10 and 25 set, junk commands presented while busy.
      run_sweep(1'b1);
      check("sweep_two_ones", ones_cnt, 2);

      // LOAD then EVAL of the same address on the next edge.
      issue(2'b01, 7, 1'b1);
      issue(2'b00, 7, 1'b0);
      check("load_then_eval", f_out, 1);

      // Randomised EVAL/LOAD mix against the model.
      for (int i = 0; i < 120; i++) begin
         int  v;
         bit  ev;
         v  = $urandom_range(0, DEPTH - 1);
         ev = 1'($urandom);
         issue(ev ? 2'b00 : 2'b01, v, 1'($urandom));
         check("rnd_fvalid", f_valid, ev);
         check("rnd_F", f_out, exp_f);
         check("rnd_ones_hold", ones_cnt, exp_ones);
      end
      run_sweep(1'b1);

      // Full table: count must reach 2^N without overflow.
      for (int a = 0; a < DEPTH; a++) issue(2'b01, a, 1'b1);
      run_sweep(1'b0);
      check("all_ones_cnt", ones_cnt, DEPTH);

      // CLEAR leaves ones_cnt alone; next sweep counts zero.
      issue(2'b11, 0, 1'b0);
      check("clear_ones_hold", ones_cnt, DEPTH);
      issue(2'b00, 31, 1'b0);
      check("clear_eval", f_out, 0);
      run_sweep(1'b0);
      check("clear_sweep_cnt", ones_cnt, 0);

      // Reset in the 10th sweep cycle aborts the sweep.
      issue(2'b01, 10, 1'b1);
      issue(2'b01, 25, 1'b1);
      issue(2'b10, 0, 1'b0);
      for (int k = 0; k < 9; k++) step();
      rst = 1'b1;
      cmd_valid = 1'b1; cmd_op = 2'b10;
      step();
      rst = 1'b0; cmd_valid = 1'b0;
      foreach (model_tbl[i]) model_tbl[i] = 1'b0;
      check("abort_ready", cmd_ready, 1);
      check("abort_done", done, 0);
      check("abort_fvalid", f_valid, 0);
      check("abort_ones", ones_cnt, 0);
      check("abort_F", f_out, 0);
      check("abort_sweep_idx", sweep_idx, 0);
      begin
         int seen = 0;
         for (int k = 0; k < DEPTH + 4; k++) begin
            step();
            if (done) seen++;
         end
         check("abort_no_done", seen, 0);
      end
      issue(2'b00, 10, 1'b0);
      check("abort_eval_F", f_out, 0);
      check("abort_eval_fvalid", f_valid, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bool_func_unit.md
# bool_func_unit

Programmable N-input Boolean function unit, the parametrised successor of the fixed 5-input combinational F(A..E) lab block. Holds a 2^N_IN-entry truth table in flops, loaded one minterm per command. Evaluates single input vectors with registered output, or sweeps all input combinations autonomously and counts the true minterms. Sits between the board switch/LED I/O and the stimulus controller used for lab verification.

## Interface
- N_IN, default 5: number of function inputs; truth table depth is 2^N_IN; legal range 2..8.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_op  in  2  command: 00 EVAL, 01 LOAD, 10 SWEEP, 11 CLEAR.
- cmd_ready  out  1  high when a command can be accepted (state IDLE).
- in_vec  in  N_IN  EVAL: input combination; LOAD: table address; in_vec[N_IN-1] is input A (MSB), in_vec[0] is the last input.
- load_bit  in  1  LOAD: value written to table[in_vec].
- F  out  1  registered function output.
- f_valid  out  1  one-cycle pulse, F is valid.
- sweep_idx  out  N_IN  input combination that produced the current F during SWEEP; 0 for EVAL results.
- ones_cnt  out  N_IN+1  number of true minterms from the last completed sweep.
- done  out  1  one-cycle pulse at sweep completion.

## Operation
- Command accepted on an edge where cmd_valid && cmd_ready; otherwise cmd_valid is ignored (no queueing).
- States: IDLE, SWEEP. cmd_ready = (state == IDLE), combinational from state.
- EVAL: F <= table[in_vec], f_valid <= 1, sweep_idx <= 0; stays IDLE.
- LOAD: table[in_vec] <= load_bit; no output change, f_valid 0.
- CLEAR: all table bits <= 0 in one cycle; ones_cnt unchanged.
- SWEEP: state <= SWEEP, internal idx <= 0, accumulator <= 0. Each SWEEP cycle: F <= table[idx], sweep_idx <= idx, f_valid <= 1, accumulator += table[idx], idx++.
- On the cycle processing idx = 2^N_IN-1: ones_cnt <= final accumulator (including that entry), done <= 1, state <= IDLE.
- Accumulator and ones_cnt are N_IN+1 bits; all-ones table yields 2^N_IN without overflow. idx is N_IN bits; terminal detection precedes wrap.
- Reset (any state, including mid-sweep): state IDLE, table all 0, F 0, f_valid 0, done 0, sweep_idx 0, ones_cnt 0, accumulator/idx 0; an aborted sweep never asserts done.
- rst has priority over any command presented in the same cycle.

## Timing
- Reset values: F=0, f_valid=0, done=0, sweep_idx=0, ones_cnt=0, cmd_ready=1.
- EVAL accepted at edge t: F/f_valid visible after edge t (1-cycle latency); f_valid low after edge t+1 unless another EVAL is accepted at t+1.
- Back-to-back EVALs: one result per cycle, throughput 1.
- LOAD at edge t followed by EVAL of the same address at edge t+1 returns the new bit.
- SWEEP accepted at edge t: cmd_ready low after edge t; results for idx k appear after edge t+1+k, k = 0..2^N_IN-1; the last result, done and the final ones_cnt all appear after edge t+2^N_IN; cmd_ready high again after the same edge. Total sweep occupancy is 2^N_IN cycles; the next command can be accepted at edge t+2^N_IN+1.
- f_valid is continuous (high every cycle) through a sweep.

## Test plan
- Reset then idle, N_IN=5: all outputs at reset values; cmd_ready=1; EVAL in_vec=5'b00000 gives F=0, f_valid=1 one cycle later.
- LOAD table[5'b01010]=1 and table[5'b11001]=1: EVAL 5'b01010 gives F=1; EVAL 5'b11001 gives F=1; EVAL 5'b00000 gives F=0; each result arrives 1 cycle after its command.
- SWEEP on that table: cmd_ready low for 32 cycles; 32 consecutive f_valid with sweep_idx 0..31; F=1 only at idx 10 and 25; done with ones_cnt=6'd2 after edge t+32.
- LOAD all 32 entries to 1, then SWEEP: ones_cnt=6'd32 (no overflow). Then CLEAR and SWEEP: ones_cnt=0.
- Command issued mid-sweep (EVAL/LOAD with cmd_valid=1): ignored; the table and the sweep results are unaffected.
- rst asserted at the 10th sweep cycle: the next edge returns IDLE, the table is cleared, done never pulses, ones_cnt=0, and EVAL of 5'b01010 returns 0.
